// File: rtl/rv_pkg.sv
// Shared register-file writeback types: widths, priority enum and the write-request payload.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned STARVE_W   = 4;

    typedef enum logic {
        PRI_LD  = 1'b0,
        PRI_ALU = 1'b1
    } wb_pri_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_prio_fsm.sv
// Writeback priority state: loads win by default, the ALU is promoted after
// STARVE_MAX consecutive denials and demoted again after one ALU transfer.
module wb_prio_fsm
    import rv_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    alu_valid,
    input  logic    ld_valid,
    input  logic    alu_xfer,
    output wb_pri_e pri
);

    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;
    logic                alu_denied;

    // The ALU is only ever refused when a load claims the port under load priority.
    assign alu_denied = alu_valid && ld_valid && (pri == PRI_LD);

    always_comb begin
        starve_nxt = starve_cnt;
        if (alu_xfer) begin
            starve_nxt = '0;
        end else if (alu_denied) begin
            starve_nxt = starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            pri        <= PRI_LD;
        end else begin
            starve_cnt <= starve_nxt;
            if (starve_nxt == STARVE_W'(STARVE_MAX)) begin
                pri <= PRI_ALU;
            end else if (alu_xfer) begin
                pri <= PRI_LD;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter between the ALU and load channels, with a retired-write
// counter. Define WB_FWD_EN to mirror the in-flight write on the fwd_* port.
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       datain,
    output logic                  reg_write,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]       fwd_data,
    output logic [CNT_W-1:0]      retired_cnt
);

    wb_pri_e pri;
    logic    alu_xfer;
    logic    ld_xfer;
    wb_req_t req;

    wb_prio_fsm #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .ld_valid  (ld_valid),
        .alu_xfer  (alu_xfer),
        .pri       (pri)
    );

    // Prioritised channel is always ready; the other only when the prioritised one is idle.
    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        if (reset) begin
            if (pri == PRI_LD) begin
                ld_ready  = 1'b1;
                alu_ready = !ld_valid;
            end else begin
                alu_ready = 1'b1;
                ld_ready  = !alu_valid;
            end
        end
    end

    assign alu_xfer = alu_valid && alu_ready;
    assign ld_xfer  = ld_valid && ld_ready;

    always_comb begin
        req = '{rd: ld_rd, data: ld_data};
        if (alu_xfer) begin
            req = '{rd: alu_rd, data: alu_data};
        end
    end

    // Writes to x0 complete the handshake but never assert the write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd        <= '0;
            datain    <= '0;
            reg_write <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            if (alu_xfer || ld_xfer) begin
                rd        <= req.rd;
                datain    <= req.data;
                reg_write <= (req.rd != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt <= '0;
        end else if (reg_write) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = reg_write;
    assign fwd_rd    = rd;
    assign fwd_data  = datain;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a driver predicts readies and writebacks from a
// denial-count model, a negedge monitor pops and compares them. Honours WB_FWD_EN.
module tb_wb_arbiter;

    localparam int unsigned XL   = 32;
    localparam int unsigned SMAX = 4;
    localparam int unsigned CW   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          alu_valid = 1'b0;
    logic [4:0]    alu_rd = '0;
    logic [XL-1:0] alu_data = '0;
    logic          alu_ready;
    logic          ld_valid = 1'b0;
    logic [4:0]    ld_rd = '0;
    logic [XL-1:0] ld_data = '0;
    logic          ld_ready;
    logic [4:0]    rd;
    logic [XL-1:0] datain;
    logic          reg_write;
    logic          fwd_valid;
    logic [4:0]    fwd_rd;
    logic [XL-1:0] fwd_data;
    logic [CW-1:0] retired_cnt;

    always #5 clk = ~clk;

    wb_arbiter #(
        .XLEN       (XL),
        .STARVE_MAX (SMAX),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .rd          (rd),
        .datain      (datain),
        .reg_write   (reg_write),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .retired_cnt (retired_cnt)
    );

    typedef struct {
        logic ar;
        logic lr;
    } rdy_exp_t;

    typedef struct {
        logic          we;
        logic [4:0]    rd;
        logic [XL-1:0] data;
        logic [CW-1:0] cnt;
    } wb_exp_t;

    rdy_exp_t    rdy_q[$];
    wb_exp_t     wb_q[$];
    int unsigned passed = 0;
    int unsigned total = 0;
    int unsigned denials = 0;
    int unsigned commits = 0;
    logic        mon_en = 1'b0;
    logic        g_alu = 1'b0;
    logic        g_ld = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    endtask

    task automatic model_reset();
        wb_exp_t e;
        denials = 0;
        commits = 0;
        rdy_q.delete();
        wb_q.delete();
        e.we = 1'b0; e.rd = '0; e.data = '0; e.cnt = '0;
        wb_q.push_back(e);
    endtask

    // One clock of stimulus plus the model's prediction for this cycle and the next.
    task automatic drive(input logic av, input logic [4:0] ard, input logic [XL-1:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [XL-1:0] ldd);
        logic     a_r;
        logic     l_r;
        rdy_exp_t r;
        wb_exp_t  e;
        @(posedge clk); #1;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid  = lv; ld_rd  = lrd; ld_data  = ldd;
        if (denials >= SMAX) begin
            a_r = 1'b1; l_r = !av;
        end else begin
            l_r = 1'b1; a_r = !lv;
        end
        g_alu = av && a_r;
        g_ld  = lv && l_r;
        r.ar = a_r; r.lr = l_r;
        rdy_q.push_back(r);
        e.we = 1'b0; e.rd = '0; e.data = '0;
        e.cnt = CW'(commits);
        if (g_alu) begin
            e.rd = ard; e.data = ad; e.we = (ard != 5'd0);
        end else if (g_ld) begin
            e.rd = lrd; e.data = ldd; e.we = (lrd != 5'd0);
        end
        wb_q.push_back(e);
        if (e.we) commits++;
        if (g_alu) denials = 0;
        else if (av) denials++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    // Random producers that hold a request stable until it is accepted.
    task automatic run_random(input int n, input int unsigned pa, input int unsigned pl);
        logic          ap;
        logic          lp;
        logic [4:0]    ar_;
        logic [4:0]    lr_;
        logic [XL-1:0] ad_;
        logic [XL-1:0] ld_;
        ap = 1'b0; lp = 1'b0; ar_ = '0; lr_ = '0; ad_ = '0; ld_ = '0;
        for (int i = 0; i < n + 40; i++) begin
            if (i < n && !ap && $urandom_range(99) < pa) begin
                ap = 1'b1; ar_ = 5'($urandom); ad_ = $urandom;
            end
            if (i < n && !lp && $urandom_range(99) < pl) begin
                lp = 1'b1; lr_ = 5'($urandom); ld_ = $urandom;
            end
            if (i >= n && !ap && !lp) break;
            drive(ap, ar_, ad_, lp, lr_, ld_);
            if (g_alu) ap = 1'b0;
            if (g_ld)  lp = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        mon_en = 1'b0; reset = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        model_reset();
        mon_en = 1'b1;
    endtask

    initial begin
        rdy_exp_t r;
        wb_exp_t  w;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rdy_q.size() == 0 || wb_q.size() == 0) begin
                    total++;
                    $display("FAIL scoreboard_empty: got empty queue expected entry at %0t", $time);
                end else begin
                    r = rdy_q.pop_front();
                    w = wb_q.pop_front();
                    check("alu_ready", 64'(alu_ready), 64'(r.ar));
                    check("ld_ready", 64'(ld_ready), 64'(r.lr));
                    check("reg_write", 64'(reg_write), 64'(w.we));
                    if (w.we) begin
                        check("rd", 64'(rd), 64'(w.rd));
                        check("datain", 64'(datain), 64'(w.data));
                    end
                    check("retired_cnt", 64'(retired_cnt), 64'(w.cnt));
`ifdef WB_FWD_EN
                    check("fwd_valid", 64'(fwd_valid), 64'(w.we));
                    if (w.we) begin
                        check("fwd_rd", 64'(fwd_rd), 64'(w.rd));
                        check("fwd_data", 64'(fwd_data), 64'(w.data));
                    end
`else
                    check("fwd_off", 64'({fwd_valid, fwd_rd, fwd_data}), 64'(0));
`endif
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with both channels requesting.
        alu_valid = 1'b1; ld_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_reg_write", 64'(reg_write), 64'(0));
        check("rst_rd", 64'(rd), 64'(0));
        check("rst_datain", 64'(datain), 64'(0));
        check("rst_retired", 64'(retired_cnt), 64'(0));
        check("rst_readies", 64'({alu_ready, ld_ready}), 64'(0));
        alu_valid = 1'b0; ld_valid = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Single ALU write, x0 load, forwarding candidate.
        drive(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, '0);
        idle(3);
        drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        idle(2);
        drive(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, '0);
        idle(2);

        // Both channels saturated, then mixed random traffic.
        run_random(12, 100, 100);
        run_random(300, 50, 50);
        run_random(200, 85, 85);
        run_random(150, 20, 90);
        idle(2);

        // Counter wrap: 17 nonzero writes on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) drive(1'b1, 5'((i % 31) + 1), $urandom, 1'b0, 5'd0, '0);
        idle(2);
        check("wrap_retired", 64'(retired_cnt), 64'(1));

        // Reset while a committed write is on the port.
        do_reset();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        mon_en = 1'b0;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        check("mid_reg_write", 64'(reg_write), 64'(1));
        check("mid_rd", 64'(rd), 64'(5));
        check("mid_datain", 64'(datain), 64'(32'hDEAD_BEEF));
        #1 reset = 1'b0;
        #1;
        check("mid_drop_we", 64'(reg_write), 64'(0));
        check("mid_drop_cnt", 64'(retired_cnt), 64'(0));
        alu_valid = 1'b1; ld_valid = 1'b1;
        #1;
        check("mid_readies", 64'({alu_ready, ld_ready}), 64'(0));
        alu_valid = 1'b0; ld_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_we", 64'(reg_write), 64'(0));
        check("post_rst_cnt", 64'(retired_cnt), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
